// File: rtl/move_queue_pkg.sv
// Shared definitions for the move queue: playback states, the NOP code and the
// default geometry used by the solver interface and the move executor.
package move_queue_pkg;

  localparam int DEF_MOVE_W = 4;
  localparam int DEF_CHUNK  = 50;
  localparam int DEF_DEPTH  = 256;

  localparam int MOVE_NOP = 0;

  typedef enum logic [2:0] {
    IDLE,
    UNPACK,
    ISSUE,
    WAIT_GAP,
    WAIT_DONE,
    STEP_HOLD,
    FINISH
  } state_t;

endpackage

// File: rtl/move_store.sv
// Move buffer: one synchronous write port, one combinational read port so the
// player can fetch buf[curr_step] in the same cycle it issues the move.
module move_store #(
  parameter int MOVE_W = 4,
  parameter int DEPTH  = 256,
  parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [MOVE_W-1:0] wr_data,
  input  logic [AW-1:0]     rd_addr,
  output logic [MOVE_W-1:0] rd_data
);

  logic [MOVE_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/move_queue.sv
// Move queue and player: unpacks chunks of move codes into the buffer (dropping
// NOPs) and plays them back to the executor over a start/done handshake.
module move_queue
  import move_queue_pkg::*;
#(
  parameter int MOVE_W = DEF_MOVE_W,
  parameter int CHUNK  = DEF_CHUNK,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    load,
  input  logic [CHUNK*MOVE_W-1:0] chunk,
  input  logic                    run,
  input  logic                    step_mode,
  input  logic                    step,
  input  logic                    abort,
  input  logic                    move_done,
  output logic                    start_move,
  output logic [MOVE_W-1:0]       next_move,
  output logic                    load_done,
  output logic                    seq_done,
  output logic                    aborted,
  output logic                    overflow,
  output logic                    busy,
  output logic [CNT_W-1:0]        num_moves,
  output logic [CNT_W-1:0]        curr_step
);

  localparam int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int SR_W   = CHUNK * MOVE_W;
  localparam int UCNT_W = $clog2(CHUNK + 1);

  state_t              state, state_next;
  logic [SR_W-1:0]     sr, sr_next;
  logic [UCNT_W-1:0]   ucnt, ucnt_next;
  logic                abort_latch, abort_latch_next;
  logic                start_move_next, load_done_next, seq_done_next;
  logic                aborted_next, overflow_next, busy_next;
  logic [MOVE_W-1:0]   next_move_next;
  logic [CNT_W-1:0]    num_moves_next, curr_step_next;

  logic                wr_en;
  logic [MOVE_W-1:0]   field;
  logic [MOVE_W-1:0]   rd_data;
  logic                abort_seen;

  move_store #(
    .MOVE_W (MOVE_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_store (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (num_moves[AW-1:0]),
    .wr_data (field),
    .rd_addr (curr_step[AW-1:0]),
    .rd_data (rd_data)
  );

  assign field = sr[SR_W-1 -: MOVE_W];

  always_comb begin
    state_next       = state;
    sr_next          = sr;
    ucnt_next        = ucnt;
    abort_latch_next = abort_latch;
    start_move_next  = 1'b0;
    next_move_next   = next_move;
    load_done_next   = 1'b0;
    seq_done_next    = 1'b0;
    aborted_next     = 1'b0;
    overflow_next    = overflow;
    num_moves_next   = num_moves;
    curr_step_next   = curr_step;
    wr_en            = 1'b0;
    abort_seen       = abort_latch | abort;

    case (state)
      IDLE: begin
        if (load) begin
          state_next = UNPACK;
          sr_next    = chunk;
          ucnt_next  = '0;
        end else if (run) begin
          state_next = (num_moves != '0) ? ISSUE : FINISH;
        end
      end

      UNPACK: begin
        // One extra cycle after the last field produces load_done.
        if (abort) begin
          abort_latch_next = 1'b1;
          state_next       = FINISH;
        end else if (ucnt == UCNT_W'(CHUNK)) begin
          load_done_next = 1'b1;
          state_next     = IDLE;
        end else begin
          sr_next   = sr << MOVE_W;
          ucnt_next = ucnt + UCNT_W'(1);
          if (field != MOVE_W'(MOVE_NOP)) begin
            if (num_moves == CNT_W'(DEPTH)) begin
              overflow_next = 1'b1;
            end else begin
              wr_en          = 1'b1;
              num_moves_next = num_moves + CNT_W'(1);
            end
          end
        end
      end

      ISSUE: begin
        next_move_next   = rd_data;
        start_move_next  = 1'b1;
        curr_step_next   = curr_step + CNT_W'(1);
        abort_latch_next = abort_seen;
        state_next       = WAIT_GAP;
      end

      WAIT_GAP: begin
        abort_latch_next = abort_seen;
        state_next       = WAIT_DONE;
      end

      WAIT_DONE: begin
        // Abort only takes effect once the executor reports the move finished.
        abort_latch_next = abort_seen;
        if (move_done) begin
          if (abort_seen || (curr_step == num_moves)) begin
            state_next = FINISH;
          end else if (step_mode) begin
            state_next = STEP_HOLD;
          end else begin
            state_next = ISSUE;
          end
        end
      end

      STEP_HOLD: begin
        if (abort) begin
          abort_latch_next = 1'b1;
          state_next       = FINISH;
        end else if (step) begin
          state_next = ISSUE;
        end
      end

      FINISH: begin
        seq_done_next    = 1'b1;
        aborted_next     = abort_latch;
        num_moves_next   = '0;
        curr_step_next   = '0;
        next_move_next   = '0;
        overflow_next    = 1'b0;
        abort_latch_next = 1'b0;
        state_next       = IDLE;
      end

      default: state_next = IDLE;
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= IDLE;
      sr          <= '0;
      ucnt        <= '0;
      abort_latch <= 1'b0;
      start_move  <= 1'b0;
      next_move   <= '0;
      load_done   <= 1'b0;
      seq_done    <= 1'b0;
      aborted     <= 1'b0;
      overflow    <= 1'b0;
      busy        <= 1'b0;
      num_moves   <= '0;
      curr_step   <= '0;
    end else begin
      state       <= state_next;
      sr          <= sr_next;
      ucnt        <= ucnt_next;
      abort_latch <= abort_latch_next;
      start_move  <= start_move_next;
      next_move   <= next_move_next;
      load_done   <= load_done_next;
      seq_done    <= seq_done_next;
      aborted     <= aborted_next;
      overflow    <= overflow_next;
      busy        <= busy_next;
      num_moves   <= num_moves_next;
      curr_step   <= curr_step_next;
    end
  end

endmodule
